// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and default constants for the pipeline sequencing controller
// and the pipeline registers it steers.
//   ctrl_state_t      : controller FSM states (RUN, FLUSH)
//   DEF_FLUSH_CYCLES  : default bubble count after a taken jump (1..7)
//   DEF_HOLD_MAX      : default stall length that trips the watchdog (1..65535)
//   DEF_RESET_PC      : default reset value of the redirect target
//   NOP_INSTR         : instruction loaded into IF/ID and ID/EX on a flush
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    localparam int          DEF_FLUSH_CYCLES = 2;
    localparam int          DEF_HOLD_MAX     = 255;
    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// ---------------------------------------------------------------------------
// hold_watchdog
// Counts consecutive stalled cycles and raises a sticky timeout once a stall
// has lasted HOLD_MAX cycles.
//   clk            in  : core clock
//   rst            in  : asynchronous active-high reset
//   stall_i        in  : pipeline is stalled this cycle
//   timeout_clr_i  in  : clears the sticky timeout
//   timeout_o      out : sticky, stall lasted HOLD_MAX cycles
// ---------------------------------------------------------------------------
module hold_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic timeout_clr_i,
    output logic timeout_o
);

    localparam logic [15:0] CNT_SAT  = 16'(HOLD_MAX);
    localparam logic [15:0] CNT_LAST = 16'(HOLD_MAX - 1);

    logic [15:0] holdCnt_q, holdCnt_d;
    logic        timeout_q, timeout_d;
    logic        setTimeout;

    // Stall counter saturates so a stuck stall never wraps back below the
    // trip point. The timeout is set on the HOLD_MAX-th consecutive stalled
    // edge; a clear arriving on that same edge loses to the set.
    always_comb begin
        holdCnt_d  = holdCnt_q;
        timeout_d  = timeout_q;
        setTimeout = stall_i && (holdCnt_q == CNT_LAST);

        if (!stall_i) begin
            holdCnt_d = '0;
        end else if (holdCnt_q < CNT_SAT) begin
            holdCnt_d = holdCnt_q + 16'd1;
        end

        if (setTimeout) begin
            timeout_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    // Watchdog state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core. Turns the EX
// branch outcome into a PC redirect plus a FLUSH_CYCLES-long bubble in IF/ID
// and ID/EX, stalls the front of the pipe on EX holds or data-bus busy, and
// watches for stuck stalls.
//   clk             in      : core clock
//   rst             in      : asynchronous active-high reset
//   jump_en_i       in      : EX branch/jump taken
//   jump_addr_i     in [32] : EX branch target
//   hold_flag_ex_i  in      : EX multi-cycle op in progress
//   mem_busy_i      in      : data bus not ready
//   timeout_clr_i   in      : clears sticky timeout_o
//   pc_set_o        out     : one-cycle PC load pulse
//   pc_addr_o       out[32] : registered redirect target
//   flush_if_id_o   out     : IF/ID loads NOP
//   flush_id_ex_o   out     : ID/EX loads NOP
//   stall_o         out     : PC, IF/ID, ID/EX hold (combinational)
//   timeout_o       out     : sticky stall timeout
// When flush and stall are both high the pipeline registers let the flush win.
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int          HOLD_MAX     = DEF_HOLD_MAX,
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        mem_busy_i,
    input  logic        timeout_clr_i,
    output logic        pc_set_o,
    output logic [31:0] pc_addr_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        stall_o,
    output logic        timeout_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    logic [2:0]  flushCnt_q, flushCnt_d;
    logic        flush_q, flush_d;
    logic        pcSet_q, pcSet_d;
    logic [31:0] pcAddr_q, pcAddr_d;
    logic        stall;
    logic        jumpTake;

    assign stall    = hold_flag_ex_i | mem_busy_i;
    assign jumpTake = jump_en_i & ~stall & (state_q == RUN);

    // Next-state logic. A jump seen while stalled is dropped because EX will
    // present it again once the stall clears; a jump seen in FLUSH is a
    // bubble and is dropped. The flush counter runs regardless of stall so
    // the bubble length is fixed.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        flush_d    = flush_q;
        pcSet_d    = 1'b0;
        pcAddr_d   = pcAddr_q;

        case (state_q)
            RUN: begin
                flush_d = 1'b0;
                if (jumpTake) begin
                    state_d    = FLUSH;
                    flushCnt_d = FLUSH_LOAD;
                    flush_d    = 1'b1;
                    pcSet_d    = 1'b1;
                    pcAddr_d   = jump_addr_i;
                end
            end
            FLUSH: begin
                if (flushCnt_q == 3'd0) begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end else begin
                    flushCnt_d = flushCnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            flushCnt_q <= '0;
            flush_q    <= 1'b0;
            pcSet_q    <= 1'b0;
            pcAddr_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            flush_q    <= flush_d;
            pcSet_q    <= pcSet_d;
            pcAddr_q   <= pcAddr_d;
        end
    end

    hold_watchdog #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .timeout_clr_i (timeout_clr_i),
        .timeout_o     (timeout_o)
    );

    assign stall_o       = stall;
    assign pc_set_o      = pcSet_q;
    assign pc_addr_o     = pcAddr_q;
    assign flush_if_id_o = flush_q;
    assign flush_id_ex_o = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl with FLUSH_CYCLES=2, HOLD_MAX=4.
// Reference model tracks remaining bubble cycles, last accepted target and
// the length of the current stall run.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int          TB_FLUSH = 2;
    localparam int          TB_HOLD  = 4;
    localparam logic [31:0] TB_PC    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        mem_busy_i;
    logic        timeout_clr_i;
    logic        pc_set_o;
    logic [31:0] pc_addr_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        stall_o;
    logic        timeout_o;

    int checkCount = 0;
    int passCount  = 0;

    int          flushLeft;
    int          runLen;
    logic        expPcSet;
    logic [31:0] expPcAddr;
    logic        expTimeout;

    pipe_ctrl #(
        .FLUSH_CYCLES (TB_FLUSH),
        .HOLD_MAX     (TB_HOLD),
        .RESET_PC     (TB_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .hold_flag_ex_i (hold_flag_ex_i),
        .mem_busy_i     (mem_busy_i),
        .timeout_clr_i  (timeout_clr_i),
        .pc_set_o       (pc_set_o),
        .pc_addr_o      (pc_addr_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .stall_o        (stall_o),
        .timeout_o      (timeout_o)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    task automatic checkEq(input string stepName, input string tag,
                           input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s/%s: observed %h expected %h", stepName, tag, obs, exp);
    endtask

    task automatic checkOutput(input string stepName);
        checkEq(stepName, "stall",    32'(stall_o),       32'(hold_flag_ex_i | mem_busy_i));
        checkEq(stepName, "pc_set",   32'(pc_set_o),      32'(expPcSet));
        checkEq(stepName, "pc_addr",  pc_addr_o,          expPcAddr);
        checkEq(stepName, "flush_if", 32'(flush_if_id_o), 32'(flushLeft > 0));
        checkEq(stepName, "flush_ex", 32'(flush_id_ex_o), 32'(flushLeft > 0));
        checkEq(stepName, "timeout",  32'(timeout_o),     32'(expTimeout));
    endtask

    task automatic modelReset();
        flushLeft  = 0;
        runLen     = 0;
        expPcSet   = 1'b0;
        expPcAddr  = TB_PC;
        expTimeout = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs present now
    task automatic modelEdge();
        logic stall;
        logic accept;
        stall  = hold_flag_ex_i | mem_busy_i;
        accept = jump_en_i && !stall && (flushLeft == 0);
        if (accept) begin
            expPcSet  = 1'b1;
            expPcAddr = jump_addr_i;
            flushLeft = TB_FLUSH;
        end else begin
            expPcSet = 1'b0;
            if (flushLeft > 0) flushLeft--;
        end
        if (stall) runLen++;
        else       runLen = 0;
        if (stall && runLen == TB_HOLD) expTimeout = 1'b1;
        else if (timeout_clr_i)         expTimeout = 1'b0;
    endtask

    task automatic applyStimulus(input logic je, input logic [31:0] ja,
                                 input logic hold, input logic busy,
                                 input logic clr, input string stepName);
        jump_en_i      = je;
        jump_addr_i    = ja;
        hold_flag_ex_i = hold;
        mem_busy_i     = busy;
        timeout_clr_i  = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(stepName);
    endtask

    task automatic idle(input int n, input string stepName);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, stepName);
    endtask

    initial begin
        // Reset, with stall following its inputs while reset is held
        rst            = 1'b1;
        jump_en_i      = 1'b0;
        jump_addr_i    = 32'h0;
        hold_flag_ex_i = 1'b1;
        mem_busy_i     = 1'b0;
        timeout_clr_i  = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_hold");
        hold_flag_ex_i = 1'b0;
        #1;
        checkOutput("reset_idle");
        @(negedge clk);
        rst = 1'b0;
        idle(1, "post_reset");

        // Plain jump to 0x40
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, "jump40");
        checkEq("jump40", "tp_addr", pc_addr_o, 32'h0000_0040);
        checkEq("jump40", "tp_set",  32'(pc_set_o), 32'd1);
        idle(1, "jump40_f2");
        checkEq("jump40_f2", "tp_flush", 32'(flush_if_id_o), 32'd1);
        idle(2, "jump40_done");
        checkEq("jump40_done", "tp_flush", 32'(flush_if_id_o), 32'd0);

        // Jump held off by EX hold, accepted once hold drops
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, "hold_jmp1");
        applyStimulus(1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b0, "hold_jmp2");
        applyStimulus(1'b1, 32'h0000_0108, 1'b1, 1'b0, 1'b0, "hold_jmp3");
        applyStimulus(1'b1, 32'h0000_010C, 1'b0, 1'b0, 1'b0, "hold_release");
        checkEq("hold_release", "tp_addr", pc_addr_o, 32'h0000_010C);
        idle(3, "hold_after");

        // Second jump during FLUSH is ignored
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, "jmp_first");
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, "jmp_in_flush1");
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, "jmp_in_flush2");
        applyStimulus(1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, "jmp_in_flush3");
        checkEq("jmp_in_flush3", "tp_addr", pc_addr_o, 32'h0000_0040);
        idle(1, "jmp_in_flush_idle");

        // Data-bus busy overlapping FLUSH
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, "busy_jmp");
        applyStimulus(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, "busy_f1");
        applyStimulus(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, "busy_f2");
        idle(2, "busy_after");

        // Reset one cycle into FLUSH, then a normal jump
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, "rst_jmp");
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_mid_flush");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, "rst_rejump");
        checkEq("rst_rejump", "tp_addr", pc_addr_o, 32'h0000_0400);
        idle(3, "rst_rejump_idle");

        // Watchdog: 4-cycle hold trips, clear drops it, 3-cycle hold does not
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "wd_hold4");
        checkEq("wd_hold4", "tp_timeout", 32'(timeout_o), 32'd1);
        idle(2, "wd_sticky");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "wd_clear");
        checkEq("wd_clear", "tp_timeout", 32'(timeout_o), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "wd_hold3");
        idle(2, "wd_hold3_after");
        checkEq("wd_hold3_after", "tp_timeout", 32'(timeout_o), 32'd0);

        // Saturated stall with clear and set contending at the trip edge
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "wd_race_pre");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "wd_race_set");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "wd_saturated");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, "wd_sat_clear");
        idle(1, "wd_done");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 9) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Consumes the execute stage's branch outcome (jump_en/jump_addr) and its multi-cycle hold request, plus the data-bus busy indication.
- Drives the PC redirect, per-stage flush and stall controls.
- Watches for stuck holds with a saturating watchdog.

Parameters:
- FLUSH_CYCLES, 2, bubble cycles forced into IF/ID and ID/EX after a taken jump (legal range 1..7)
- HOLD_MAX, 255, consecutive stall cycles before timeout_o sets (legal range 1..65535)
- RESET_PC, 32'h0000_0000, reset value of pc_addr_o

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_en_i  in  1  EX: branch/jump taken this cycle
- jump_addr_i  in  32  EX: branch target, valid when jump_en_i=1
- hold_flag_ex_i  in  1  EX: multi-cycle op in progress, EX result not valid
- mem_busy_i  in  1  data bus not ready for current load/store
- timeout_clr_i  in  1  clears sticky timeout_o
- pc_set_o  out  1  one-cycle pulse: PC loads pc_addr_o
- pc_addr_o  out  32  registered redirect target
- flush_if_id_o  out  1  IF/ID register loads NOP
- flush_id_ex_o  out  1  ID/EX register loads NOP
- stall_o  out  1  PC, IF/ID, ID/EX hold current value
- timeout_o  out  1  sticky: stall lasted HOLD_MAX cycles

Behaviour:
- Reset (async, any state):
  - state=RUN, flush counter=0, hold counter=0.
  - pc_set_o=0, pc_addr_o=RESET_PC, flush_if_id_o=0, flush_id_ex_o=0, timeout_o=0.
  - stall_o is combinational, so it follows its inputs even during reset.
- stall_o = hold_flag_ex_i | mem_busy_i, combinational, zero latency. It is the only combinational output.
- Jump acceptance condition: jump_take = jump_en_i & ~stall_o & (state==RUN).
  - Jumps presented while stalled are ignored; EX re-presents them when the stall drops.
  - Jumps presented in FLUSH are ignored, because EX holds a flushed bubble.
- FSM states: RUN, FLUSH.
- RUN:
  - On an edge where jump_take=1:
    - Next cycle: pc_set_o=1 for exactly one cycle, pc_addr_o=jump_addr_i (captured).
    - flush_if_id_o=flush_id_ex_o=1.
    - Flush counter loads FLUSH_CYCLES-1; state goes to FLUSH.
  - Otherwise all flush and pc_set outputs are 0.
- FLUSH:
  - Flush outputs stay 1.
  - Counter decrements every cycle, regardless of stall_o.
  - When the counter is 0 at the edge: flush outputs go to 0 and state goes to RUN.
  - Total flush assertion is exactly FLUSH_CYCLES cycles, starting the cycle after jump_take.
- Stall and flush together: both outputs are asserted. Pipeline registers give flush priority over stall (documented contract for the pipeline registers).
- pc_addr_o holds its last captured value when pc_set_o=0.
- Hold watchdog:
  - 16-bit counter increments on each cycle stall_o=1 and clears on any cycle stall_o=0.
  - It saturates at HOLD_MAX.
  - timeout_o sets on the edge where counter==HOLD_MAX-1 and stall_o=1, i.e. timeout_o rises after HOLD_MAX consecutive stalled cycles.
  - timeout_o stays set until timeout_clr_i=1.
  - If timeout_clr_i=1 and the set condition hold in the same cycle, set wins.
- Widths: flush counter is 3 bits; jump_addr_i is passed through unmodified (EX has already added the offset).

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RUN, FLUSH}.
  - Default constants for FLUSH_CYCLES, HOLD_MAX, RESET_PC.
  - NOP instruction constant 32'h0000_0013, shared with the pipeline registers.
- One sub-module: hold_watchdog, containing the stall counter and sticky timeout_o with clr.
- FSM, flush counter and PC redirect remain in pipe_ctrl.

Test Plan:
- Reset mid-FLUSH (rst pulsed 1 cycle after jump_take): all outputs return to reset values immediately, pc_addr_o=0, state RUN; the next jump works normally.
- jump_en_i=1, jump_addr_i=32'h0000_0040, no stall: the next cycle has pc_set_o=1 and pc_addr_o=0x40 for 1 cycle; flush_if_id_o/flush_id_ex_o are high for exactly 2 cycles; then all are 0.
- jump_en_i=1 together with hold_flag_ex_i=1 for 3 cycles, then jump_en_i=1 with hold dropped: stall_o=1 for the 3 cycles with no pc_set_o; pc_set_o pulses only after the hold drops; target is captured from the final cycle.
- Jump accepted, then jump_en_i=1 (target 0x80) during the FLUSH cycles: the second jump is ignored and pc_addr_o stays 0x40.
- mem_busy_i high for 2 cycles during FLUSH: flush still lasts exactly 2 cycles and stall_o=1 concurrently.
- HOLD_MAX=4, hold_flag_ex_i=1 for 4 cycles: timeout_o rises after the 4th stalled edge and stays high after the hold drops; timeout_clr_i=1 for one cycle clears it; a 3-cycle hold never sets it.
